bomberman_audio_sample_fifo: RTL and testbench
==============================================

BOMBERMAN_AUDIO_SAMPLE_FIFO -- requirements
Module: bomberman_audio_sample_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning sample width in bits (left/right packed by software).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries, a power of two from 4 to 256.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 chipselect  input  1  Avalon-MM slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, combinational, zero wait states.
REQ-011 out_data  output  DATA_W  head-of-FIFO sample to the codec serializer.
REQ-012 out_valid  output  1  head sample available.
REQ-013 out_ready  input  1  serializer consumes the head this cycle.
REQ-014 irq  output  1  level interrupt, low-watermark.

Function
REQ-015 A write SHALL occur when chipselect=1 and write_n=0; reads are side-effect free.
REQ-016 Address 0 write SHALL push writedata[DATA_W-1:0]; address 0 read SHALL return the last pushed value, zero-extended.
REQ-017 Address 1 read SHALL return status: [8:0] level, [16] full, [17] empty, [18] overflow, [19] underflow, other bits 0.
REQ-018 Address 1 write SHALL clear overflow for writedata[18]=1 and underflow for writedata[19]=1 (W1C); other bits are ignored.
REQ-019 Address 2 SHALL be the read/write watermark register, bits [8:0], other bits read 0.
REQ-020 Address 3 SHALL be control: [0] enable, [1] irq_en, read/write; [2] flush, write-only, self-clearing, reads 0.
REQ-021 out_valid SHALL equal enable AND NOT empty, combinationally.
REQ-022 out_data SHALL equal the entry at the read pointer, combinationally, and is undefined-but-stable when empty.
REQ-023 A pop SHALL occur when out_valid=1 and out_ready=1 and advance the read pointer next edge.
REQ-024 Underflow SHALL be set when enable=1, empty=1 and out_ready=1.
REQ-025 A push to a full FIFO with no pop in the same cycle SHALL be dropped and set overflow.
REQ-026 A simultaneous push and pop when full SHALL both be accepted with the level unchanged.
REQ-027 A push into an empty FIFO SHALL raise out_valid the next cycle; no same-cycle bypass.
REQ-028 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; the level is a separate counter from 0 to DEPTH.
REQ-029 Flush SHALL zero the pointers and level on the next edge, and overrides any push or pop in that cycle.
REQ-030 Flush SHALL leave the sticky flags, watermark and enable bits unchanged.
REQ-031 irq SHALL be a registered output equal to irq_en AND enable AND (level <= watermark), updated every cycle.
REQ-032 Sticky flags SHALL hold until cleared by W1C; a set and a clear in the same cycle leaves the flag set.

Reset
REQ-033 While reset_n=0, the block SHALL be in the following state: pointers, level, last-pushed value, flags, watermark and control all 0.
REQ-034 In reset, out_valid, irq and readdata SHALL be 0, and the FIFO SHALL be empty.
REQ-035 Reset SHALL act mid-operation without a clock edge and discard all contents.

Verification
REQ-036 Reset, then push 0xAAAA0001..0xAAAA0003, then set enable: out_valid=1, out_data=0xAAAA0001; three ready cycles drain in order, then empty=1.
REQ-037 DEPTH=16, enable=0, 17 pushes: status reads level=16, full=1, overflow=1; after enable, the 16th value out is the 16th pushed value.
REQ-038 Full FIFO with enable=1 and out_ready=1 plus a push the same cycle: level stays 16, overflow stays 0, and the new value exits last.
REQ-039 Enable with an empty FIFO and out_ready=1 for one cycle: underflow=1; W1C write 0x00080000 to address 1 clears it.
REQ-040 Watermark=4, irq_en=1, enable=1, 6 entries: irq=0; after 2 pops, irq=1 one cycle after the level reaches 4; writing flush gives level=0 and irq stays 1.
REQ-041 Assert reset_n=0 mid-drain with 10 entries: out_valid, level and irq fall to 0 immediately, and the first push after release exits first.

Source files
------------

// File: rtl/bomberman_audio_sample_fifo.sv
// Audio sample FIFO between an Avalon-MM slave (software pushes samples) and the
// codec serializer (valid/ready pop side), with sticky error flags and a low-watermark irq.
module bomberman_audio_sample_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [LW-1:0]     level;
    logic [8:0]        level_ext;
    logic [DATA_W-1:0] last_pushed;
    logic              overflow;
    logic              underflow;
    logic [8:0]        watermark;
    logic              enable;
    logic              irq_en;

    logic bus_write;
    logic push_req;
    logic flush;
    logic full;
    logic empty;
    logic pop;
    logic push_ok;
    logic pop_ok;
    logic overflow_set;
    logic underflow_set;
    logic overflow_clr;
    logic underflow_clr;

    assign bus_write = chipselect && !write_n;
    assign push_req  = bus_write && (address == 2'd0);
    assign flush     = bus_write && (address == 2'd3) && writedata[2];

    assign full      = (level == FULL_LEVEL);
    assign empty     = (level == '0);
    assign level_ext = 9'(level);

    assign out_valid = enable && !empty;
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok       = push_req && (!full || pop) && !flush;
    assign pop_ok        = pop && !flush;
    assign overflow_set  = push_req && full && !pop;
    assign underflow_set = enable && empty && out_ready;
    assign overflow_clr  = bus_write && (address == 2'd1) && writedata[18];
    assign underflow_clr = bus_write && (address == 2'd1) && writedata[19];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= writedata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            last_pushed <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr      <= wr_ptr + 1'b1;
                last_pushed <= writedata[DATA_W-1:0];
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Set wins over a same-cycle write-one-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
            if (underflow_set) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            watermark <= '0;
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (bus_write && (address == 2'd2)) begin
                watermark <= writedata[8:0];
            end
            if (bus_write && (address == 2'd3)) begin
                enable <= writedata[0];
                irq_en <= writedata[1];
            end
            irq <= irq_en && enable && (level_ext <= watermark);
        end
    end

    // Gated by reset so the status word (empty=1) does not leak out during reset.
    always_comb begin
        readdata = '0;
        if (reset_n) begin
            case (address)
                2'd0: readdata[DATA_W-1:0] = last_pushed;
                2'd1: begin
                    readdata[8:0] = level_ext;
                    readdata[16]  = full;
                    readdata[17]  = empty;
                    readdata[18]  = overflow;
                    readdata[19]  = underflow;
                end
                2'd2:    readdata[8:0] = watermark;
                default: readdata[1:0] = {irq_en, enable};
            endcase
        end
    end

endmodule

// File: tb/tb_bomberman_audio_sample_fifo.sv
// Directed self-checking bench for bomberman_audio_sample_fifo (DATA_W=32, DEPTH=16)
// with hand-computed expected values checked by immediate assertions.
module tb_bomberman_audio_sample_fifo;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rd;

    bomberman_audio_sample_fifo #(.DATA_W(32), .DEPTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One Avalon write, issued at a falling edge and taken on the next rising edge.
    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic busRead(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic popOne();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        out_ready  = 1'b0;
        #3;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        checkOutput("rst_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        busRead(2'd1, rd);
        checkOutput("post_rst_status", rd, 32'h0002_0000);

        $display("[TB] in-order drain of three samples");
        for (int i = 1; i <= 3; i++) applyStimulus(2'd0, 32'hAAAA_0000 + 32'(i));
        busRead(2'd0, rd);
        checkOutput("last_pushed", rd, 32'hAAAA_0003);
        checkOutput("valid_while_disabled", 32'(out_valid), 32'h0);
        applyStimulus(2'd3, 32'h1);
        checkOutput("valid_after_enable", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            checkOutput($sformatf("drain3_%0d", i), out_data, 32'hAAAA_0000 + 32'(i));
            @(negedge clk);
        end
        out_ready = 1'b0;
        busRead(2'd1, rd);
        checkOutput("drain3_empty_status", rd, 32'h0002_0000);
        checkOutput("drain3_valid_low", 32'(out_valid), 32'h0);

        $display("[TB] overflow with 17 pushes while disabled");
        applyStimulus(2'd3, 32'h0);
        for (int i = 1; i <= 17; i++) applyStimulus(2'd0, 32'hB000_0000 + 32'(i));
        busRead(2'd1, rd);
        checkOutput("overflow_status", rd, 32'h0005_0010);
        applyStimulus(2'd3, 32'h1);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            checkOutput($sformatf("drain16_%0d", i), out_data, 32'hB000_0000 + 32'(i));
            @(negedge clk);
        end
        out_ready = 1'b0;
        applyStimulus(2'd1, 32'h0004_0000);
        busRead(2'd1, rd);
        checkOutput("overflow_cleared", rd, 32'h0002_0000);

        $display("[TB] push and pop together while full");
        applyStimulus(2'd3, 32'h0);
        for (int i = 1; i <= 16; i++) applyStimulus(2'd0, 32'hC000_0000 + 32'(i));
        applyStimulus(2'd3, 32'h1);
        @(negedge clk);
        out_ready  = 1'b1;
        address    = 2'd0;
        writedata  = 32'hC000_0011;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        out_ready  = 1'b0;
        busRead(2'd1, rd);
        checkOutput("full_push_pop_status", rd, 32'h0001_0010);
        out_ready = 1'b1;
        for (int i = 2; i <= 17; i++) begin
            checkOutput($sformatf("full_drain_%0d", i), out_data, 32'hC000_0000 + 32'(i));
            @(negedge clk);
        end
        out_ready = 1'b0;

        $display("[TB] underflow and W1C");
        popOne();
        busRead(2'd1, rd);
        checkOutput("underflow_status", rd, 32'h000A_0000);
        applyStimulus(2'd1, 32'h0008_0000);
        busRead(2'd1, rd);
        checkOutput("underflow_cleared", rd, 32'h0002_0000);

        $display("[TB] low-watermark irq and flush");
        applyStimulus(2'd2, 32'h4);
        busRead(2'd2, rd);
        checkOutput("watermark_readback", rd, 32'h4);
        for (int i = 1; i <= 6; i++) applyStimulus(2'd0, 32'hD000_0000 + 32'(i));
        applyStimulus(2'd3, 32'h3);
        @(negedge clk);
        checkOutput("irq_six_entries", 32'(irq), 32'h0);
        popOne();
        popOne();
        busRead(2'd1, rd);
        checkOutput("level_four", rd, 32'h0000_0004);
        checkOutput("irq_same_cycle_level4", 32'(irq), 32'h0);
        @(negedge clk);
        checkOutput("irq_after_level4", 32'(irq), 32'h1);
        applyStimulus(2'd3, 32'h7);
        busRead(2'd1, rd);
        checkOutput("flush_status", rd, 32'h0002_0000);
        checkOutput("irq_after_flush", 32'(irq), 32'h1);
        busRead(2'd3, rd);
        checkOutput("ctrl_after_flush", rd, 32'h3);
        busRead(2'd2, rd);
        checkOutput("watermark_after_flush", rd, 32'h4);

        $display("[TB] asynchronous reset mid-drain");
        applyStimulus(2'd2, 32'h10);
        for (int i = 1; i <= 10; i++) applyStimulus(2'd0, 32'hE000_0000 + 32'(i));
        checkOutput("irq_before_reset", 32'(irq), 32'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("midreset_irq", 32'(irq), 32'h0);
        busRead(2'd1, rd);
        checkOutput("midreset_status", rd, 32'h0);
        out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        busRead(2'd1, rd);
        checkOutput("post_midreset_status", rd, 32'h0002_0000);
        applyStimulus(2'd0, 32'hF000_0001);
        applyStimulus(2'd0, 32'hF000_0002);
        applyStimulus(2'd3, 32'h1);
        checkOutput("post_midreset_valid", 32'(out_valid), 32'h1);
        checkOutput("post_midreset_head", out_data, 32'hF000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
